// File: rtl/fw_loader_xmodem.sv
// XMODEM firmware loader: pulls blocks from the Rx FIFO, answers through the Tx FIFO
// and writes the payload into IMEM, committing the write pointer only on an ACKed block.
module fw_loader_xmodem #(
  parameter int unsigned NB_DATA         = 8,
  parameter int unsigned NB_INSTRUCTION  = 32,
  parameter int unsigned IMEM_ADDR_WIDTH = 8,
  parameter int unsigned BLOCK_BYTES     = 128,
  parameter int unsigned USE_CRC         = 0,
  parameter int unsigned POLL_PERIOD     = 400_000_000,
  parameter int unsigned BYTE_TIMEOUT    = 100_000_000,
  parameter int unsigned MAX_RETRIES     = 10
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_rx_valid,
  input  logic [NB_DATA-1:0]         i_rx_data,
  output logic                       o_rx_rd,
  input  logic                       i_tx_full,
  output logic                       o_tx_wr,
  output logic [NB_DATA-1:0]         o_tx_data,
  output logic                       o_imem_wen,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_waddr,
  output logic [NB_INSTRUCTION-1:0]  o_imem_data,
  output logic                       o_done,
  output logic                       o_error
);
  localparam int unsigned WB      = NB_INSTRUCTION / 8;
  localparam int unsigned CNT_MAX = (POLL_PERIOD > BYTE_TIMEOUT) ? POLL_PERIOD : BYTE_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BB_W    = $clog2(BLOCK_BYTES + 1);
  localparam int unsigned BI_W    = $clog2(WB + 1);
  localparam int unsigned RT_W    = $clog2(MAX_RETRIES + 2);
  localparam int unsigned WP_W    = IMEM_ADDR_WIDTH + 1;

  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] EOT = 8'h04;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [7:0] CAN = 8'h18;
  localparam logic [7:0] POLL_BYTE = (USE_CRC != 0) ? 8'h43 : NAK;

  typedef enum logic [3:0] {
    S_IDLE, S_BLK, S_NBLK, S_DATA, S_CK_HI, S_CK_LO, S_RESP, S_DONE, S_ABORT
  } state_t;

  state_t                    r_state, w_next;
  logic [CNT_W-1:0]          r_cnt;
  logic [7:0]                r_blk, r_last_ok, r_sum, r_ck_hi, r_resp;
  logic [15:0]               r_crc;
  logic [BB_W-1:0]           r_bytes;
  logic [BI_W-1:0]           r_bidx;
  logic [RT_W-1:0]           r_retries;
  logic [WP_W-1:0]           r_wptr, r_base;
  logic [NB_INSTRUCTION-1:0] r_word;
  logic [1:0]                r_can_cnt;
  logic                      r_any_ok, r_dup, r_eot, r_ovf, r_done, r_error;
  logic                      r_imem_wen;
  logic [IMEM_ADDR_WIDTH-1:0] r_imem_waddr;
  logic [NB_INSTRUCTION-1:0] r_imem_data;

  logic                      w_rx_rd, w_tx_wr, w_poll, w_fail, w_pass;
  logic                      w_timeout, w_last_byte, w_ck_ok;
  logic [7:0]                w_tx_data, w_expect;
  logic [NB_INSTRUCTION-1:0] w_word;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] x;
    x = c ^ {b, 8'h00};
    for (int unsigned i = 0; i < 8; i++)
      x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
    return x;
  endfunction

  assign w_timeout   = (r_cnt == CNT_W'(BYTE_TIMEOUT));
  assign w_expect    = r_last_ok + 8'd1;
  assign w_last_byte = (r_bytes == BB_W'(BLOCK_BYTES - 1));
  assign w_ck_ok     = (USE_CRC != 0) ? ({r_ck_hi, i_rx_data} == r_crc) : (i_rx_data == r_sum);
  // First received byte of a word ends up in the low byte after WB shifts.
  assign w_word      = (r_word >> 8) | (NB_INSTRUCTION'(i_rx_data) << (NB_INSTRUCTION - 8));

  always_ff @(posedge clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_rx_rd   = 1'b0;
    w_tx_wr   = 1'b0;
    w_tx_data = r_resp;
    w_poll    = 1'b0;
    w_fail    = 1'b0;
    w_pass    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_rx_rd = i_rx_valid;
        if (r_cnt == CNT_W'(POLL_PERIOD - 1)) begin
          w_poll    = 1'b1;
          w_tx_wr   = ~i_tx_full;
          w_tx_data = POLL_BYTE;
        end
        if (i_rx_valid) begin
          if (i_rx_data == SOH)                  w_next = S_BLK;
          else if (i_rx_data == EOT && r_any_ok) w_next = S_RESP;
          else if (i_rx_data == CAN)             w_next = S_ABORT;
        end
      end
      S_BLK, S_NBLK, S_DATA, S_CK_HI, S_CK_LO: begin
        if (w_timeout) begin
          w_fail = 1'b1;
        end else if (i_rx_valid) begin
          w_rx_rd = 1'b1;
          case (r_state)
            S_BLK:   w_next = S_NBLK;
            S_NBLK: begin
              if (i_rx_data != ~r_blk)                                    w_fail = 1'b1;
              else if (r_blk == w_expect || (r_any_ok && r_blk == r_last_ok)) w_next = S_DATA;
              else                                                        w_next = S_ABORT;
            end
            S_DATA:  if (w_last_byte) w_next = (USE_CRC != 0) ? S_CK_HI : S_CK_LO;
            S_CK_HI: w_next = S_CK_LO;
            default: begin
              if (r_ovf)        w_next = S_ABORT;
              else if (w_ck_ok) begin w_pass = 1'b1; w_next = S_RESP; end
              else              w_fail = 1'b1;
            end
          endcase
        end
        if (w_fail) w_next = (r_retries == RT_W'(MAX_RETRIES)) ? S_ABORT : S_RESP;
      end
      S_RESP: begin
        w_tx_wr = ~i_tx_full;
        if (!i_tx_full) w_next = r_eot ? S_DONE : S_IDLE;
      end
      S_DONE: w_rx_rd = i_rx_valid;
      S_ABORT: begin
        w_rx_rd = i_rx_valid;
        if (r_can_cnt != 2'd2) begin
          w_tx_wr   = ~i_tx_full;
          w_tx_data = CAN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_cnt <= '0;  r_blk <= '0;  r_last_ok <= '0; r_sum <= '0; r_ck_hi <= '0;
      r_resp <= '0; r_crc <= '0;  r_bytes <= '0;   r_bidx <= '0; r_retries <= '0;
      r_wptr <= '0; r_base <= '0; r_word <= '0;    r_can_cnt <= '0;
      r_any_ok <= 1'b0; r_dup <= 1'b0; r_eot <= 1'b0; r_ovf <= 1'b0;
      r_done <= 1'b0; r_error <= 1'b0;
      r_imem_wen <= 1'b0; r_imem_waddr <= '0; r_imem_data <= '0;
    end else begin
      r_imem_wen <= 1'b0;
      if (w_poll || w_rx_rd || w_next != r_state) r_cnt <= '0;
      else                                        r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == S_IDLE && w_rx_rd && i_rx_data == SOH) begin
        r_sum <= '0; r_crc <= '0; r_bytes <= '0; r_bidx <= '0; r_ovf <= 1'b0;
      end
      if (r_state == S_IDLE && w_next == S_RESP) begin
        r_resp <= ACK;
        r_eot  <= 1'b1;
      end
      if (r_state == S_BLK && w_rx_rd)   r_blk <= i_rx_data;
      if (r_state == S_NBLK && w_rx_rd)  r_dup <= (r_blk != w_expect);
      if (r_state == S_CK_HI && w_rx_rd) r_ck_hi <= i_rx_data;
      if (r_state == S_DATA && w_rx_rd) begin
        r_sum   <= r_sum + i_rx_data;
        r_crc   <= crc_step(r_crc, i_rx_data);
        r_bytes <= r_bytes + BB_W'(1);
        if (!r_dup) begin
          r_word <= w_word;
          if (r_bidx == BI_W'(WB - 1)) begin
            r_bidx <= '0;
            // The extra wptr bit marks "past the top of IMEM"; such writes are dropped.
            if (r_wptr[IMEM_ADDR_WIDTH]) begin
              r_ovf <= 1'b1;
            end else begin
              r_imem_wen   <= 1'b1;
              r_imem_waddr <= r_wptr[IMEM_ADDR_WIDTH-1:0];
              r_imem_data  <= w_word;
              r_wptr       <= r_wptr + WP_W'(WB);
            end
          end else begin
            r_bidx <= r_bidx + BI_W'(1);
          end
        end
      end
      if (w_pass) begin
        r_last_ok <= r_blk;
        r_any_ok  <= 1'b1;
        r_base    <= r_wptr;
        r_retries <= '0;
        r_resp    <= ACK;
        r_eot     <= 1'b0;
      end
      if (w_fail) begin
        r_wptr    <= r_base;
        r_retries <= r_retries + RT_W'(1);
        r_resp    <= NAK;
        r_eot     <= 1'b0;
      end
      if (r_state == S_RESP && w_tx_wr && r_eot) r_done <= 1'b1;
      if (r_state == S_ABORT && w_tx_wr) begin
        r_can_cnt <= r_can_cnt + 2'd1;
        r_error   <= 1'b1;
      end
    end
  end

  assign o_rx_rd      = w_rx_rd & ~i_rst;
  assign o_tx_wr      = w_tx_wr & ~i_rst;
  assign o_tx_data    = w_tx_data;
  assign o_imem_wen   = r_imem_wen;
  assign o_imem_waddr = r_imem_waddr;
  assign o_imem_data  = r_imem_data;
  assign o_done       = r_done  | (r_state == S_RESP  && r_eot && o_tx_wr);
  assign o_error      = r_error | (r_state == S_ABORT && o_tx_wr);

endmodule

// File: tb/tb_fw_loader_xmodem.sv
// Directed bench: checksum-mode loader (a_*) and CRC-mode loader (b_*) driven in turn.
module tb_fw_loader_xmodem;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       a_rx_valid, a_rx_rd, a_tx_full, a_tx_wr, a_wen, a_done, a_err;
  logic [7:0] a_rx_data, a_tx_data, a_waddr;
  logic [31:0] a_wdata;
  logic       b_rx_valid, b_rx_rd, b_tx_full, b_tx_wr, b_wen, b_done, b_err;
  logic [7:0] b_rx_data, b_tx_data, b_waddr;
  logic [31:0] b_wdata;

  fw_loader_xmodem #(.USE_CRC(0), .POLL_PERIOD(5000), .BYTE_TIMEOUT(50), .MAX_RETRIES(3)) u_a (
    .clk(clk), .i_rst(rst), .i_rx_valid(a_rx_valid), .i_rx_data(a_rx_data), .o_rx_rd(a_rx_rd),
    .i_tx_full(a_tx_full), .o_tx_wr(a_tx_wr), .o_tx_data(a_tx_data), .o_imem_wen(a_wen),
    .o_imem_waddr(a_waddr), .o_imem_data(a_wdata), .o_done(a_done), .o_error(a_err));

  fw_loader_xmodem #(.USE_CRC(1), .POLL_PERIOD(40), .BYTE_TIMEOUT(50), .MAX_RETRIES(3)) u_b (
    .clk(clk), .i_rst(rst), .i_rx_valid(b_rx_valid), .i_rx_data(b_rx_data), .o_rx_rd(b_rx_rd),
    .i_tx_full(b_tx_full), .o_tx_wr(b_tx_wr), .o_tx_data(b_tx_data), .o_imem_wen(b_wen),
    .o_imem_waddr(b_waddr), .o_imem_data(b_wdata), .o_done(b_done), .o_error(b_err));

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [7:0]  a_txq[$];
  logic [7:0]  b_txq[$];
  int unsigned b_txt[$];
  logic [7:0]  a_wa[$];
  logic [31:0] a_wd[$];
  logic [7:0]  pay [0:127];
  logic [7:0]  rb;
  logic [15:0] crc;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_tx_wr) a_txq.push_back(a_tx_data);
    if (a_wen) begin a_wa.push_back(a_waddr); a_wd.push_back(a_wdata); end
    if (b_tx_wr) begin b_txq.push_back(b_tx_data); b_txt.push_back(cyc); end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input bit sel, input logic [7:0] b);
    int unsigned n;
    n = 0;
    @(negedge clk);
    if (sel) begin b_rx_valid = 1'b1; b_rx_data = b; end
    else     begin a_rx_valid = 1'b1; a_rx_data = b; end
    #1;
    while (!(sel ? b_rx_rd : a_rx_rd) && n < 64) begin @(negedge clk); #1; n++; end
    if (!(sel ? b_rx_rd : a_rx_rd)) chk("rx_pop", 32'(sel ? b_rx_rd : a_rx_rd), 32'd1);
    @(posedge clk);
  endtask

  task automatic rx_idle(input bit sel);
    @(negedge clk);
    if (sel) b_rx_valid = 1'b0; else a_rx_valid = 1'b0;
  endtask

  // Polls ('C') from the CRC loader are skipped when looking for a response.
  task automatic wait_tx(input bit sel, input int unsigned lim, output logic [7:0] b);
    b = 8'h00;
    for (int unsigned n = 0; n < lim; n++) begin
      @(negedge clk);
      if (sel) while (b_txq.size() > 0 && b_txq[0] == 8'h43) void'(b_txq.pop_front());
      if (sel ? (b_txq.size() > 0) : (a_txq.size() > 0)) begin
        b = sel ? b_txq.pop_front() : a_txq.pop_front();
        break;
      end
    end
  endtask

  task automatic fill_ramp(input logic [7:0] base);
    for (int i = 0; i < 128; i++) pay[i] = base + 8'(i);
  endtask

  task automatic send_head_payload(input bit sel, input logic [7:0] blk);
    put(sel, 8'h01); put(sel, blk); put(sel, ~blk);
    for (int i = 0; i < 128; i++) put(sel, pay[i]);
  endtask

  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c;
    logic fb;
    c = 16'h0000;
    for (int i = 0; i < n; i++)
      for (int j = 7; j >= 0; j--) begin
        fb = c[15] ^ pay[i][j];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    return c;
  endfunction

  initial begin
    rst = 1'b1;
    a_rx_valid = 1'b0; a_rx_data = '0; a_tx_full = 1'b0;
    b_rx_valid = 1'b0; b_rx_data = '0; b_tx_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_tx_wr",  32'(a_tx_wr), 32'd0);
    chk("rst_wen",    32'(a_wen),   32'd0);
    chk("rst_waddr",  32'(a_waddr), 32'd0);
    chk("rst_wdata",  a_wdata,      32'd0);
    chk("rst_done",   32'(a_done),  32'd0);
    chk("rst_error",  32'(a_err),   32'd0);
    chk("rst_rx_rd",  32'(a_rx_rd), 32'd0);
    chk("rst_b_err",  32'(b_err),   32'd0);

    // Block 1 with a bad checksum, then the correct resend.
    fill_ramp(8'h00);
    a_wa.delete(); a_wd.delete();
    send_head_payload(1'b0, 8'h01); put(1'b0, 8'hC1); rx_idle(1'b0);
    wait_tx(1'b0, 20, rb);
    chk("bad_ck_nak", 32'(rb), 32'h15);
    chk("bad_ck_nwr", a_wa.size(), 32);

    a_wa.delete(); a_wd.delete();
    send_head_payload(1'b0, 8'h01); put(1'b0, 8'hC0); rx_idle(1'b0);
    wait_tx(1'b0, 20, rb);
    chk("blk1_ack",   32'(rb), 32'h06);
    chk("blk1_nwr",   a_wa.size(), 32);
    if (a_wa.size() == 32) begin
      chk("blk1_addr0", 32'(a_wa[0]),  32'h00);
      chk("blk1_data0", a_wd[0],       32'h03020100);
      chk("blk1_addrN", 32'(a_wa[31]), 32'h7C);
      chk("blk1_dataN", a_wd[31],      32'h7F7E7D7C);
    end

    // Duplicate of block 1: ACKed, nothing written.
    a_wa.delete(); a_wd.delete();
    send_head_payload(1'b0, 8'h01); put(1'b0, 8'hC0); rx_idle(1'b0);
    wait_tx(1'b0, 20, rb);
    chk("dup_ack", 32'(rb), 32'h06);
    chk("dup_nwr", a_wa.size(), 0);

    // Block 2 (sum of 0x80..0xFF = 0x5FC0), ACK held back by a full Tx FIFO.
    fill_ramp(8'h80);
    a_wa.delete(); a_wd.delete();
    send_head_payload(1'b0, 8'h02);
    a_tx_full = 1'b1;
    put(1'b0, 8'hC0); rx_idle(1'b0);
    repeat (20) @(negedge clk);
    #1;
    chk("full_hold_wr", 32'(a_tx_wr), 32'd0);
    chk("full_hold_q",  a_txq.size(), 0);
    a_tx_full = 1'b0;
    #1;
    chk("full_release_wr", 32'(a_tx_wr), 32'd1);
    wait_tx(1'b0, 5, rb);
    chk("blk2_ack", 32'(rb), 32'h06);
    chk("blk2_nwr", a_wa.size(), 32);
    if (a_wa.size() == 32) begin
      chk("blk2_addr0", 32'(a_wa[0]),  32'h80);
      chk("blk2_data0", a_wd[0],       32'h83828180);
      chk("blk2_addrN", 32'(a_wa[31]), 32'hFC);
    end
    chk("pre_eot_done", 32'(a_done), 32'd0);

    put(1'b0, 8'h04); rx_idle(1'b0);
    wait_tx(1'b0, 10, rb);
    chk("eot_ack", 32'(rb), 32'h06);
    repeat (3) @(negedge clk);
    chk("done_set",   32'(a_done), 32'd1);
    chk("done_noerr", 32'(a_err),  32'd0);

    // CRC loader: poll spacing.
    @(negedge clk);
    b_txq.delete(); b_txt.delete();
    for (int n = 0; n < 120 && b_txt.size() < 2; n++) @(negedge clk);
    chk("poll_count", b_txt.size() >= 2, 1);
    if (b_txt.size() >= 2) begin
      chk("poll_byte", 32'(b_txq[0]), 32'h43);
      chk("poll_gap",  b_txt[1] - b_txt[0], 40);
    end

    // "123456789" padded with SUB.
    for (int i = 0; i < 128; i++) pay[i] = (i < 9) ? 8'(8'h31 + i) : 8'h1A;
    crc = crc_model(128);
    send_head_payload(1'b1, 8'h01); put(1'b1, crc[15:8]); put(1'b1, crc[7:0]); rx_idle(1'b1);
    wait_tx(1'b1, 20, rb);
    chk("crc_ack", 32'(rb), 32'h06);

    send_head_payload(1'b1, 8'h02); put(1'b1, crc[15:8]); put(1'b1, crc[7:0] ^ 8'h01); rx_idle(1'b1);
    wait_tx(1'b1, 20, rb);
    chk("crc_bad_nak", 32'(rb), 32'h15);

    send_head_payload(1'b1, 8'h02); put(1'b1, crc[15:8]); put(1'b1, crc[7:0]); rx_idle(1'b1);
    wait_tx(1'b1, 20, rb);
    chk("crc_resend_ack", 32'(rb), 32'h06);

    // Stalled blocks: three NAKs, the fourth failure aborts.
    for (int k = 0; k < 4; k++) begin
      put(1'b1, 8'h01); put(1'b1, 8'h03); put(1'b1, 8'hFC);
      for (int i = 0; i < 5; i++) put(1'b1, pay[i]);
      rx_idle(1'b1);
      wait_tx(1'b1, 150, rb);
      if (k < 3) chk("stall_nak", 32'(rb), 32'h15);
      else       chk("abort_can1", 32'(rb), 32'h18);
    end
    wait_tx(1'b1, 10, rb);
    chk("abort_can2", 32'(rb), 32'h18);
    repeat (5) @(negedge clk);
    chk("abort_error",  32'(b_err),  32'd1);
    chk("abort_nodone", 32'(b_done), 32'd0);
    chk("abort_quiet",  b_txq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
